// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared state encoding and default widths for the scan sequencer.
package scan_seq_pkg;

   localparam int unsigned LINE_W  = 8;
   localparam int unsigned FOCUS_W = 2;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StRx,
      StGap,
      StEnd
   } state_e;

endpackage

// File: rtl/scan_seq_timer.sv
// scan_seq_timer: loadable down-counter that stops at zero; done flags the last cycle of a phase.
module scan_seq_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign count = count_q;
   assign done  = (count_q == '0);

endmodule

// File: rtl/scan_seq_gen.sv
// scan_seq_gen: runtime-configured scan sequencer producing per-firing gates and line/focus indices.
// Define SCAN_SEQ_LOOP_EN for continuous frames: END re-enters PREP until stop is seen.
module scan_seq_gen #(
   parameter int unsigned LINE_W  = scan_seq_pkg::LINE_W,
   parameter int unsigned FOCUS_W = scan_seq_pkg::FOCUS_W,
   parameter int unsigned CNT_W   = scan_seq_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stop,
   input  logic [LINE_W-1:0]  cfg_num_lines,
   input  logic [FOCUS_W-1:0] cfg_num_focus,
   input  logic [CNT_W-1:0]   cfg_pr_len,
   input  logic [CNT_W-1:0]   cfg_rx_len,
   input  logic [CNT_W-1:0]   cfg_sample_dly,
   input  logic [CNT_W-1:0]   cfg_gap_len,
   output logic [LINE_W-1:0]  Line_Num,
   output logic [FOCUS_W-1:0] Focus_Num,
   output logic               Pr_Gate,
   output logic               RX_Gate,
   output logic               Sample_Gate,
   output logic               Envelop,
   output logic               End_Gate,
   output logic               busy
);
   import scan_seq_pkg::*;

   localparam logic [CNT_W:0] IdxOne = {{CNT_W{1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [LINE_W-1:0]  last_line_q, line_d;
   logic [FOCUS_W-1:0] last_focus_q, focus_d;
   logic [CNT_W-1:0]   pr_m1_q, rx_m1_q, gap_m1_q, dly_q;
   logic               gap_zero_q, stop_seen_q;
   logic [CNT_W-1:0]   pr_m1_in, tmr_val, tmr_cnt;
   logic               tmr_load, tmr_done;
   logic               relatch, decide, stop_any, last_firing, sample_d;
   logic [CNT_W:0]     rx_idx_next;

   assign pr_m1_in    = (cfg_pr_len == '0) ? '0 : cfg_pr_len - CNT_W'(1);
   assign stop_any    = stop_seen_q | stop;
   assign last_firing = (Focus_Num == last_focus_q) && (Line_Num == last_line_q);

   always_comb begin
      state_d = state_q;
      line_d  = Line_Num;
      focus_d = Focus_Num;
      decide  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               state_d = StPrep;
               line_d  = '0;
               focus_d = '0;
            end
         end
         StPrep: if (tmr_done) state_d = StRx;
         StRx: begin
            if (tmr_done) begin
               if (gap_zero_q) decide = 1'b1;
               else            state_d = StGap;
            end
         end
         StGap: if (tmr_done) decide = 1'b1;
         StEnd: begin
`ifdef SCAN_SEQ_LOOP_EN
            if (stop_any) begin
               state_d = StIdle;
            end else begin
               state_d = StPrep;
               line_d  = '0;
               focus_d = '0;
            end
`else
            state_d = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase

      // Focus is the inner index; the line advances when focus wraps.
      if (decide) begin
         if (stop_any || last_firing) begin
            state_d = StEnd;
         end else begin
            state_d = StPrep;
            if (Focus_Num == last_focus_q) begin
               focus_d = '0;
               line_d  = Line_Num + LINE_W'(1);
            end else begin
               focus_d = Focus_Num + FOCUS_W'(1);
            end
         end
      end
   end

   assign relatch  = (state_d == StPrep) && ((state_q == StIdle) || (state_q == StEnd));
   assign tmr_load = (state_d != state_q) && (state_d inside {StPrep, StRx, StGap});

   always_comb begin
      tmr_val = '0;
      case (state_d)
         StPrep:  tmr_val = relatch ? pr_m1_in : pr_m1_q;
         StRx:    tmr_val = rx_m1_q;
         StGap:   tmr_val = gap_m1_q;
         default: tmr_val = '0;
      endcase
   end

   // RX index of the upcoming cycle, derived from the remaining count.
   always_comb begin
      rx_idx_next = {1'b0, rx_m1_q} - {1'b0, tmr_cnt} + IdxOne;
      sample_d    = 1'b0;
      if (state_d == StRx) begin
         if (state_q != StRx) sample_d = (dly_q == '0);
         else                 sample_d = (rx_idx_next >= {1'b0, dly_q});
      end
   end

   scan_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_cnt),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         Line_Num     <= '0;
         Focus_Num    <= '0;
         Pr_Gate      <= 1'b0;
         RX_Gate      <= 1'b0;
         Sample_Gate  <= 1'b0;
         Envelop      <= 1'b0;
         End_Gate     <= 1'b0;
         busy         <= 1'b0;
         stop_seen_q  <= 1'b0;
         last_line_q  <= '0;
         last_focus_q <= '0;
         pr_m1_q      <= '0;
         rx_m1_q      <= '0;
         gap_m1_q     <= '0;
         dly_q        <= '0;
         gap_zero_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         Line_Num    <= line_d;
         Focus_Num   <= focus_d;
         Pr_Gate     <= (state_d == StPrep);
         RX_Gate     <= (state_d == StRx);
         Sample_Gate <= sample_d;
         Envelop     <= (state_d inside {StPrep, StRx, StGap});
         End_Gate    <= (state_d == StEnd);
         busy        <= (state_d != StIdle);

         if (state_q == StEnd)                    stop_seen_q <= 1'b0;
         else if (stop && (state_q != StIdle))    stop_seen_q <= 1'b1;

         if (relatch) begin
            last_line_q  <= cfg_num_lines - LINE_W'(1);
            last_focus_q <= (cfg_num_focus == '0) ? '0 : cfg_num_focus - FOCUS_W'(1);
            pr_m1_q      <= pr_m1_in;
            rx_m1_q      <= (cfg_rx_len == '0) ? '0 : cfg_rx_len - CNT_W'(1);
            gap_m1_q     <= (cfg_gap_len == '0) ? '0 : cfg_gap_len - CNT_W'(1);
            gap_zero_q   <= (cfg_gap_len == '0);
            dly_q        <= cfg_sample_dly;
         end
      end
   end

endmodule

// File: tb/tb_scan_seq_gen.sv
// tb_scan_seq_gen: cycle-by-cycle comparison of scan_seq_gen against a frame-level trace model.
// Honours SCAN_SEQ_LOOP_EN the same way as the design.
module tb_scan_seq_gen;

   localparam int LW = 4;
   localparam int FW = 2;
   localparam int CW = 16;

   typedef logic [11:0] vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start, stop;
   logic [LW-1:0] cfg_num_lines;
   logic [FW-1:0] cfg_num_focus;
   logic [CW-1:0] cfg_pr_len, cfg_rx_len, cfg_sample_dly, cfg_gap_len;
   logic [LW-1:0] Line_Num;
   logic [FW-1:0] Focus_Num;
   logic          Pr_Gate, RX_Gate, Sample_Gate, Envelop, End_Gate, busy;
   vec_t          obs;

   int   n_checks, n_errors;
   int   last_l, last_f, model_frames;
   vec_t exp_q[$];
   int   ec, sn;

   always #5 clk = ~clk;

   scan_seq_gen #(
      .LINE_W  (LW),
      .FOCUS_W (FW),
      .CNT_W   (CW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .stop           (stop),
      .cfg_num_lines  (cfg_num_lines),
      .cfg_num_focus  (cfg_num_focus),
      .cfg_pr_len     (cfg_pr_len),
      .cfg_rx_len     (cfg_rx_len),
      .cfg_sample_dly (cfg_sample_dly),
      .cfg_gap_len    (cfg_gap_len),
      .Line_Num       (Line_Num),
      .Focus_Num      (Focus_Num),
      .Pr_Gate        (Pr_Gate),
      .RX_Gate        (RX_Gate),
      .Sample_Gate    (Sample_Gate),
      .Envelop        (Envelop),
      .End_Gate       (End_Gate),
      .busy           (busy)
   );

   assign obs = {Line_Num, Focus_Num, Pr_Gate, RX_Gate, Sample_Gate, Envelop, End_Gate, busy};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic vec_t mk(input int l, input int f, input logic pr, input logic rx,
                               input logic sm, input logic env, input logic eg, input logic bz);
      mk = {LW'(l), FW'(f), pr, rx, sm, env, eg, bz};
   endfunction

   // Trace of one run: firings in focus-inner order, each P+R+G cycles, then one END cycle.
   task automatic build_model(input int nl, input int nf, input int p, input int r,
                              input int dly, input int g, input int stop_at, input int tail);
      int  period, c, ll, lf;
      bit  stopped, done;
      exp_q.delete();
      period = p + r + g;
      c = 0; ll = 0; lf = 0; stopped = 0; done = 0; model_frames = 0;
      while (!done) begin
         stopped = 0;
         for (int f = 0; f < nl * nf && !stopped; f++) begin
            ll = f / nf;
            lf = f % nf;
            for (int k = 0; k < period; k++) begin
               exp_q.push_back(mk(ll, lf, k < p, (k >= p) && (k < p + r),
                                  (k >= p + dly) && (k < p + r), 1'b1, 1'b0, 1'b1));
               if (c == stop_at) stopped = 1;
               c++;
            end
         end
         exp_q.push_back(mk(ll, lf, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
         model_frames++;
`ifdef SCAN_SEQ_LOOP_EN
         if (c == stop_at) stopped = 1;
         done = stopped;
`else
         done = 1;
`endif
         c++;
      end
      for (int i = 0; i < tail; i++)
         exp_q.push_back(mk(ll, lf, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      last_l = ll;
      last_f = lf;
   endtask

   task automatic set_cfg(input int nl, input int nf, input int p, input int r,
                          input int dly, input int g);
      cfg_num_lines  = LW'(nl);
      cfg_num_focus  = FW'(nf);
      cfg_pr_len     = CW'(p);
      cfg_rx_len     = CW'(r);
      cfg_sample_dly = CW'(dly);
      cfg_gap_len    = CW'(g);
   endtask

   // stop_in: -1 none, -2 random cycle, otherwise cycle index (0 = first Pr_Gate cycle).
   task automatic run_frame(input int nl_cfg, input int nf_cfg, input int p_cfg, input int r_cfg,
                            input int dly, input int g, input int stop_in,
                            output int end_c, output int samp_n);
      int nl, nf, p, r, flen, stop_at;
      nl = (nl_cfg == 0) ? (1 << LW) : nl_cfg;
      nf = (nf_cfg == 0) ? 1 : nf_cfg;
      p  = (p_cfg == 0) ? 1 : p_cfg;
      r  = (r_cfg == 0) ? 1 : r_cfg;
      flen = nl * nf * (p + r + g) + 1;
      stop_at = (stop_in == -2) ? int'($urandom_range(0, flen)) : stop_in;
`ifdef SCAN_SEQ_LOOP_EN
      if (stop_at < 0) stop_at = 3 * flen - 1;
`endif
      build_model(nl, nf, p, r, dly, g, stop_at, 3);
      set_cfg(nl_cfg, nf_cfg, p_cfg, r_cfg, dly, g);
      start  = 1'b1;
      end_c  = -1;
      samp_n = 0;
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge clk);
         start = 1'b0;
         check_val($sformatf("cyc%0d", c), 32'(obs), 32'(exp_q[c]));
         if (End_Gate && end_c < 0) end_c = c;
         if (Sample_Gate) samp_n++;
         stop = (c == stop_at);
         if (exp_q[c][0] && ($urandom_range(0, 3) == 0)) start = 1'b1;
`ifndef SCAN_SEQ_LOOP_EN
         if (c == 1) set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
`endif
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val(tag, 32'(obs), 32'(mk(last_l, last_f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      start    = 1'b0;
      stop     = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      reset_n  = 1'b1;
      #2 reset_n = 1'b0;
      #1 check_val("reset", 32'(obs), 32'd0);
      repeat (2) @(negedge clk);
      check_val("reset_hold", 32'(obs), 32'd0);
      reset_n = 1'b1;
      last_l = 0;
      last_f = 0;
      idle_cycles(2, "idle0");

      // 2 lines x 3 focus, 16-cycle period, End_Gate 97 cycles after start.
      run_frame(2, 3, 4, 10, 3, 2, -1, ec, sn);
      check_val("end_cyc", ec, 96);
      check_val("samp_cnt", sn, model_frames * 6 * 7);

      run_frame(2, 3, 4, 10, 12, 2, -1, ec, sn);
      check_val("samp_none", sn, 0);

      // Clamps: focus 0 -> 1, P 0 -> 1, G 0 -> back-to-back firings.
      run_frame(3, 0, 0, 5, 1, 0, -1, ec, sn);
      check_val("clamp_end", ec, 3 * 6);

      // Line count 0 means 16 lines.
      run_frame(0, 1, 1, 1, 0, 0, -1, ec, sn);
      check_val("lines16_end", ec, 32);

      // Stop during RX of the second firing.
      run_frame(2, 3, 4, 10, 3, 2, 23, ec, sn);
      check_val("stop_end", ec, 32);
      check_val("stop_idx", 32'({Line_Num, Focus_Num}), 32'({4'd0, 2'd1}));

      // start and stop together in IDLE must not start a frame.
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check_val("start_stop_idle", 32'(obs),
                32'(mk(last_l, last_f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
      idle_cycles(2, "start_stop_hold");

      // Asynchronous reset in the middle of RX.
      build_model(2, 2, 3, 8, 2, 1, 0, 0);
      set_cfg(2, 2, 3, 8, 2, 1);
      start = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         check_val($sformatf("pre_rst%0d", c), 32'(obs), 32'(exp_q[c]));
      end
      #2 reset_n = 1'b0;
      #1 check_val("rst_async", 32'(obs), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check_val("rst_hold", 32'(obs), 32'd0);
      end
      reset_n = 1'b1;
      last_l = 0;
      last_f = 0;
      idle_cycles(3, "rst_idle");

      for (int i = 0; i < 12; i++) begin
         run_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 3),
                   ($urandom_range(0, 1) == 0) ? -1 : -2, ec, sn);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
